// File: rtl/mem_pkg.sv
// Shared opcode constants, FSM state encoding and access-classification helpers
// for the memory-access stage and its store formatter.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b001010;
  localparam logic [5:0] OP_LH  = 6'b001011;
  localparam logic [5:0] OP_LW  = 6'b001100;
  localparam logic [5:0] OP_LBU = 6'b001101;
  localparam logic [5:0] OP_LHU = 6'b001110;
  localparam logic [5:0] OP_SB  = 6'b001111;
  localparam logic [5:0] OP_SH  = 6'b010000;
  localparam logic [5:0] OP_SW  = 6'b010001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_t;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic acc_size_t access_size(input logic [5:0] op);
    acc_size_t sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      OP_LW, OP_SW:         sz = SZ_WORD;
      default:              sz = SZ_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-side, data-memory and write-back signals of the memory-access stage.
// master is the stage itself; slave is the surrounding pipeline and memory.
interface mem_access_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;

  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dbe;
  logic        dack;
  logic [31:0] drdata;

  logic        out_valid;
  logic [5:0]  out_op;
  logic [31:0] out_addr;
  logic [31:0] out_rdata;
  logic        out_misaligned;
  logic        out_timeout;

  modport master (
    input  in_valid, in_op, in_addr, in_wdata, dack, drdata,
    output in_ready, dreq, dwe, daddr, dwdata, dbe,
           out_valid, out_op, out_addr, out_rdata, out_misaligned, out_timeout
  );

  modport slave (
    output in_valid, in_op, in_addr, in_wdata, dack, drdata,
    input  in_ready, dreq, dwe, daddr, dwdata, dbe,
           out_valid, out_op, out_addr, out_rdata, out_misaligned, out_timeout
  );
endinterface

// File: rtl/store_align.sv
// Combinational store formatter: lane-replicates write data, builds byte enables
// and flags misaligned half/word accesses. Loads and other ops yield zero enables.
module store_align
  import mem_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] dwdata,
  output logic [3:0]  dbe,
  output logic        misaligned
);

  acc_size_t sz;

  always_comb begin
    sz         = access_size(op);
    dwdata     = '0;
    dbe        = '0;
    misaligned = 1'b0;

    case (sz)
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase

    if (is_store(op)) begin
      case (sz)
        SZ_BYTE: begin
          dwdata = {4{wdata[7:0]}};
          dbe    = 4'b0001 << addr_lo;
        end
        SZ_HALF: begin
          dwdata = {2{wdata[15:0]}};
          dbe    = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
        SZ_WORD: begin
          dwdata = wdata;
          dbe    = '1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one aligned data-memory access at a time
// over a req/ack handshake with timeout, and returns a one-cycle result pulse.
module mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.master bus
);

  state_t          state;
  logic [TW-1:0]   cnt;
  logic [5:0]      op_q;
  logic [31:0]     addr_q;

  logic [31:0]     al_wdata;
  logic [3:0]      al_be;
  logic            al_mis;
  logic            mem_op;

  store_align u_align (
    .op         (bus.in_op),
    .addr_lo    (bus.in_addr[1:0]),
    .wdata      (bus.in_wdata),
    .dwdata     (al_wdata),
    .dbe        (al_be),
    .misaligned (al_mis)
  );

  always_comb begin
    mem_op = is_load(bus.in_op) || is_store(bus.in_op);
  end

  // Result fields are loaded only on the edge entering RESP so they hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      cnt                <= '0;
      op_q               <= '0;
      addr_q             <= '0;
      bus.in_ready       <= 1'b1;
      bus.dreq           <= 1'b0;
      bus.dwe            <= 1'b0;
      bus.daddr          <= '0;
      bus.dwdata         <= '0;
      bus.dbe            <= '0;
      bus.out_valid      <= 1'b0;
      bus.out_op         <= '0;
      bus.out_addr       <= '0;
      bus.out_rdata      <= '0;
      bus.out_misaligned <= 1'b0;
      bus.out_timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q         <= bus.in_op;
            addr_q       <= bus.in_addr;
            bus.in_ready <= 1'b0;
            if (mem_op && !al_mis) begin
              state      <= S_ACCESS;
              cnt        <= '0;
              bus.dreq   <= 1'b1;
              bus.dwe    <= is_store(bus.in_op);
              bus.daddr  <= {bus.in_addr[31:2], 2'b00};
              bus.dwdata <= al_wdata;
              bus.dbe    <= al_be;
            end else begin
              state              <= S_RESP;
              bus.out_valid      <= 1'b1;
              bus.out_op         <= bus.in_op;
              bus.out_addr       <= bus.in_addr;
              bus.out_rdata      <= '0;
              bus.out_misaligned <= al_mis;
              bus.out_timeout    <= 1'b0;
            end
          end
        end

        S_ACCESS: begin
          // An ack on the timeout edge still wins: check dack before the counter.
          if (bus.dack) begin
            state              <= S_RESP;
            bus.dreq           <= 1'b0;
            bus.dwe            <= 1'b0;
            bus.out_valid      <= 1'b1;
            bus.out_op         <= op_q;
            bus.out_addr       <= addr_q;
            bus.out_rdata      <= is_load(op_q) ? bus.drdata : '0;
            bus.out_misaligned <= 1'b0;
            bus.out_timeout    <= 1'b0;
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            state              <= S_RESP;
            bus.dreq           <= 1'b0;
            bus.dwe            <= 1'b0;
            bus.out_valid      <= 1'b1;
            bus.out_op         <= op_q;
            bus.out_addr       <= addr_q;
            bus.out_rdata      <= '0;
            bus.out_misaligned <= 1'b0;
            bus.out_timeout    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RESP: begin
          state         <= S_IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end

        default: begin
          state         <= S_IDLE;
          bus.dreq      <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage that sits between the execute stage and the write-back stage and drives the data-memory port. For stores it aligns write data to the addressed byte lanes and generates byte enables. For loads it issues the word read and forwards the raw, unshifted 32-bit word so write-back can extract and extend it. It holds the pipeline through a variable-latency request/acknowledge handshake with a timeout, and it flags misaligned accesses instead of issuing them.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum cycles `dreq` stays high waiting for `dack` before the access is aborted.
- `TW`, 5: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: execute stage presents an instruction.
- `in_ready` out 1: stage can accept; high only in IDLE.
- `in_op` in 6: opcode.
- `in_addr` in 32: effective address (ALU result).
- `in_wdata` in 32: store source register value.
- `dreq` out 1: memory request.
- `dwe` out 1: write request (stores only).
- `daddr` out 32: word address; bits [1:0] are always 0.
- `dwdata` out 32: lane-replicated store data.
- `dbe` out 4: byte enables; bit i enables `dwdata[8i+7:8i]`.
- `dack` in 1: memory accepts or completes the access.
- `drdata` in 32: read word, valid when `dack` is high.
- `out_valid` out 1: one-cycle result pulse to write-back.
- `out_op` out 6: opcode of the completed instruction.
- `out_addr` out 32: full byte address of the completed instruction.
- `out_rdata` out 32: raw read word (0 for non-loads).
- `out_misaligned` out 1: alignment fault; no memory access was made.
- `out_timeout` out 1: access aborted with no `dack`.

## Operation
- Loads: LB 001010, LH 001011, LW 001100, LBU 001101, LHU 001110.
- Stores: SB 001111, SH 010000, SW 010001.
- All other opcodes are pass-through.
- Alignment:
  - LH, LHU, SH are misaligned if `addr[0]`=1.
  - LW, SW are misaligned if `addr[1:0]`≠00.
  - Byte accesses are never misaligned.
- Store formatting:
  - SB: `dwdata` = 4 copies of `wdata[7:0]`; `dbe` = 0001 << `addr[1:0]`.
  - SH: `dwdata` = 2 copies of `wdata[15:0]`; `dbe` = 1100 if `addr[1]` else 0011.
  - SW: `dwdata` = `wdata`; `dbe` = 1111.
- Loads drive `dwe`=0 and `dbe`=0000.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE, `in_valid`, memory op, aligned: capture all inputs, clear the timeout counter, go to ACCESS.
  - IDLE, `in_valid`, pass-through op or misaligned: capture, go to RESP with `out_misaligned` set as applicable.
  - ACCESS: `dreq` held high with all memory outputs stable.
    - On `dack`: capture `drdata` (loads) and go to RESP.
    - On counter = TIMEOUT-1 without `dack`: set `out_timeout` and go to RESP.
  - RESP: `out_valid`=1 for exactly one cycle, then go to IDLE.
- `out_rdata` is 0 for stores, pass-through ops, faulted and timed-out accesses.
- `out_*` fields hold their values until the next RESP.

## Timing
- Reset values: state IDLE; `in_ready`=1; all other outputs 0.
- Reset asserted mid-ACCESS drops `dreq` immediately (asynchronous) and abandons the access; no `out_valid` is produced.
- Pass-through or misaligned op accepted at edge k: `out_valid` is high in cycle k+1, and `in_ready` is high again in cycle k+2.
- Memory op accepted at edge k: `dreq` is high from cycle k+1.
  - `dack` sampled at edge k+n: `out_valid` is high in cycle k+n+1.
  - Minimum latency is 2 cycles.
- `dack` sampled high in the same edge as the timeout condition counts as an ack: normal completion, no timeout.
- `dack` while `dreq` is low is ignored.
- `in_valid` while `in_ready`=0 is ignored; the upstream stage must hold its instruction until `in_ready`.
- At most one access is outstanding.

## Structure
- Shared package `mem_pkg` holds:
  - the opcode constants above;
  - the state encoding;
  - the functions `is_load`, `is_store`, and `access_size`.
- One sub-module, `store_align`: purely combinational; (op, addr[1:0], wdata) → (dwdata, dbe, misaligned). It is reusable by a future write buffer.
- The FSM, timeout counter and output registers live in `mem_access`.

## Test plan
- SB at 0x0000_1003 with wdata 0x1234_56AB, `dack` after 3 cycles:
  - `daddr` 0x0000_1000, `dbe` 1000, `dwdata` 0xABAB_ABAB, `dwe` 1;
  - `out_valid` 4 cycles after acceptance, `out_rdata` 0.
- LW at 0x0000_2000, `dack` in the first `dreq` cycle with `drdata` 0xDEAD_BEEF: `out_rdata` 0xDEAD_BEEF, 2-cycle latency, `dbe` 0000.
- SH at 0x0000_3001:
  - `dreq` never asserted;
  - `out_misaligned`=1, `out_valid` next cycle;
  - a LHU at 0x0000_3002 then completes normally.
- LB with no `dack`, TIMEOUT=16: `dreq` high for exactly 16 cycles, then `out_timeout`=1, `out_valid`=1, `out_rdata`=0.
- Pass-through opcode 000010 back-to-back with a SW at 0x10: `in_ready` low one cycle between them; results arrive in order.
- Reset asserted during ACCESS: `dreq` low within the same cycle, no `out_valid`; next instruction accepted normally.
